cost_table_reader: RTL
======================

Name: cost_table_reader

Overview:
- Read-side counterpart of the learn-costs writer.
- On a start pulse, walks the cost table in the byte-wide data memory and assembles each 4-word entry (sourceID, batteryStat, value, clusterID).
- Selects the lowest-cost eligible entry and reports it with a done pulse.
- Sits between the shared 1024x8 memory and the next-hop/cluster-head decision logic.

Parameters:
- MEM_DEPTH, 1024, bytes in data memory
- ADDR_WIDTH, 10, memory address width
- MEM_WIDTH, 8, memory data width
- WORD_WIDTH, 16, field width
- ENTRY_BYTES, 8, bytes per table entry (4 words)
- MAX_ENTRIES, 128, largest scannable table (MEM_DEPTH/ENTRY_BYTES)

Ports:
- clock  in  1  system clock
- nreset  in  1  synchronous active-low reset
- start_read  in  1  one-cycle start pulse
- base_addr  in  ADDR_WIDTH  byte address of entry 0, sampled on start
- num_entries  in  8  entries to scan, sampled on start
- min_battery  in  WORD_WIDTH  eligibility threshold, sampled on start
- mem_addr  out  ADDR_WIDTH  read address
- mem_rd_en  out  1  read strobe
- mem_rdata  in  MEM_WIDTH  read data, valid one cycle after mem_rd_en
- best_sourceID, best_batteryStat, best_value, best_clusterID  out  WORD_WIDTH each  selected entry
- found  out  1  an eligible entry was selected
- busy  out  1  scan in progress
- done_read  out  1  one-cycle completion pulse

Behaviour:
- Reset: nreset is synchronous, active-low; clock is clock. Reset values:
  - state IDLE
  - mem_addr=0, mem_rd_en=0, busy=0, done_read=0, found=0
  - all best_* = 16'hFFFF
- Entry layout: 8 consecutive bytes, big-endian words (high byte at lower address), in this order: sourceID, batteryStat, value, clusterID.
- States: IDLE, READ, FINISH.
- IDLE:
  - start_read=1 latches base_addr, num_entries, min_battery and clears the running minimum.
  - num_entries clamps to MAX_ENTRIES if larger.
  - num_entries=0 -> FINISH directly.
  - Otherwise -> READ.
- READ:
  - Cycle k (k=1..8N, cycle 0 = start sample): mem_rd_en=1, mem_addr=(base+k-1) mod MEM_DEPTH. Addresses wrap past 1023 to 0.
  - Byte k is captured at cycle k+1 into an assembly register.
  - When the 8th byte of an entry arrives, the entry is compared in that same cycle:
    - Eligible when batteryStat >= min_battery (unsigned).
    - Replaces the current best when eligible and (no best yet, or value < best value, unsigned).
    - Ties keep the earlier entry.
  - The state moves to FINISH after the final byte is captured. mem_rd_en=0 from cycle 8N+1 onward.
- FINISH: done_read=1 for exactly one cycle, then IDLE.
  - N>0: done at cycle 8N+2.
  - N=0: done at cycle 1.
- Output update:
  - best_* and found update only on the done_read cycle and hold until the next done.
  - found=0 -> best_* = 16'hFFFF.
- busy=1 from cycle 1 through the done_read cycle inclusive.
- start_read while busy is ignored: no restart, no re-latching.
- Reset mid-scan aborts immediately to reset values. No done_read is produced.
- Inputs other than mem_rdata are ignored while busy.

Decomposition:
- Shared package holds:
  - MEM_DEPTH, MEM_WIDTH, WORD_WIDTH, ENTRY_BYTES
  - field byte offsets (SRC=0, BATT=2, VAL=4, CLU=6)
  - the entry record typedef, shared with the learn-costs writer so both ends agree on layout
- One natural sub-module: entry_assembler (byte counter 0..7 plus a 64-bit shift/assembly register; emits entry_valid with the 4 fields).
- Comparison and FSM stay in the top.

Test Plan:
- Basic scan: base=0, N=3, min_battery=0, values 0x0050/0x0020/0x0030 (src 1/2/3) -> done at cycle 26, found=1, best_sourceID=2, best_value=0x0020.
- Tie and battery filter: N=3, values 0x0010/0x0010/0x0005, battery 0x0100/0x0100/0x0010, min_battery=0x0080 -> best_sourceID=entry 0, value 0x0010.
- None eligible: N=2, all batteryStat=0, min_battery=1 -> found=0, best_*=0xFFFF. Also N=0 -> done at cycle 1, found=0, no mem_rd_en.
- Wrap-around: base=1020, N=1 -> reads addresses 1020..1023 then 0..3. Entry is assembled correctly across the wrap.
- Start while busy: second start_read at cycle 5 of an N=2 scan -> ignored; single done at cycle 18. Clamp: num_entries=200 -> 1024 reads, done at cycle 1026.
- Reset mid-scan: nreset low at cycle 10 -> next cycle mem_rd_en=0, busy=0, best_*=0xFFFF. A new start afterwards completes normally.

Source files
------------

// File: rtl/cost_table_reader_pkg.sv
// cost_table_reader_pkg
// Shared definitions for the cost table, used by both the learn-costs writer
// and this reader so that both ends agree on the table layout.
//   - memory geometry and word width
//   - byte offsets of each field inside an 8-byte entry
//   - entry_t record and the reader FSM state type
//   - unpack_entry(): big-endian 8-byte image -> entry_t
package cost_table_reader_pkg;

    localparam int MEM_DEPTH   = 1024;
    localparam int ADDR_WIDTH  = 10;
    localparam int MEM_WIDTH   = 8;
    localparam int WORD_WIDTH  = 16;
    localparam int ENTRY_BYTES = 8;
    localparam int MAX_ENTRIES = MEM_DEPTH / ENTRY_BYTES;

    // Byte offsets of each word inside an entry (high byte at the lower address).
    localparam int OFS_SRC  = 0;
    localparam int OFS_BATT = 2;
    localparam int OFS_VAL  = 4;
    localparam int OFS_CLU  = 6;

    localparam logic [WORD_WIDTH-1:0] EMPTY_WORD = 16'hFFFF;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] source_id;
        logic [WORD_WIDTH-1:0] battery_stat;
        logic [WORD_WIDTH-1:0] value;
        logic [WORD_WIDTH-1:0] cluster_id;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // The byte at entry offset 0 sits in the most significant byte of 'bytes'.
    function automatic entry_t unpack_entry(input logic [ENTRY_BYTES*MEM_WIDTH-1:0] bytes);
        entry_t e;
        e.source_id    = bytes[ENTRY_BYTES*MEM_WIDTH-1-OFS_SRC*MEM_WIDTH  -: WORD_WIDTH];
        e.battery_stat = bytes[ENTRY_BYTES*MEM_WIDTH-1-OFS_BATT*MEM_WIDTH -: WORD_WIDTH];
        e.value        = bytes[ENTRY_BYTES*MEM_WIDTH-1-OFS_VAL*MEM_WIDTH  -: WORD_WIDTH];
        e.cluster_id   = bytes[ENTRY_BYTES*MEM_WIDTH-1-OFS_CLU*MEM_WIDTH  -: WORD_WIDTH];
        return e;
    endfunction

endpackage

// File: rtl/cost_table_reader_if.sv
// cost_table_reader_if
// Read port of the shared 1024x8 data memory.
//   mem_addr  : byte address            (master -> memory)
//   mem_rd_en : read strobe             (master -> memory)
//   mem_rdata : read data, valid the cycle after mem_rd_en (memory -> master)
interface cost_table_reader_if
    import cost_table_reader_pkg::*;
();
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic [MEM_WIDTH-1:0]  mem_rdata;

    modport master (output mem_addr, output mem_rd_en, input  mem_rdata);
    modport slave  (input  mem_addr, input  mem_rd_en, output mem_rdata);
endinterface

// File: rtl/cost_table_reader_entry_assembler.sv
// cost_table_reader_entry_assembler
// Collects the byte stream returned by memory into 8-byte entries.
//   clock, nreset  : clock, synchronous active-low reset
//   i_clear        : restart at byte 0 (new scan)
//   i_byte_valid   : i_byte carries the next table byte this cycle
//   i_byte         : table byte
//   o_entry_valid  : this cycle's byte completes an entry
//   o_entry        : the completed entry (valid with o_entry_valid)
module cost_table_reader_entry_assembler
    import cost_table_reader_pkg::*;
(
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 i_clear,
    input  logic                 i_byte_valid,
    input  logic [MEM_WIDTH-1:0] i_byte,
    output logic                 o_entry_valid,
    output entry_t               o_entry
);
    localparam int CNT_W = $clog2(ENTRY_BYTES);

    logic [CNT_W-1:0]                       r_count;
    // Holds the first seven bytes; the eighth is taken straight from i_byte so
    // the entry is available in the cycle its last byte arrives.
    logic [(ENTRY_BYTES-1)*MEM_WIDTH-1:0]   r_shift;

    always_ff @(posedge clock) begin
        if (!nreset || i_clear) begin
            r_count <= '0;
            r_shift <= '0;
        end else if (i_byte_valid) begin
            r_count <= r_count + CNT_W'(1);
            r_shift <= {r_shift[(ENTRY_BYTES-2)*MEM_WIDTH-1:0], i_byte};
        end
    end

    assign o_entry_valid = i_byte_valid && (r_count == CNT_W'(ENTRY_BYTES-1));
    assign o_entry       = unpack_entry({r_shift, i_byte});

endmodule

// File: rtl/cost_table_reader.sv
// cost_table_reader
// Scans the cost table in data memory and reports the lowest-value entry
// whose battery status is at least min_battery.
//   clock, nreset       : clock, synchronous active-low reset
//   i_start_read        : one-cycle start pulse (ignored while busy)
//   i_base_addr         : byte address of entry 0
//   i_num_entries       : entries to scan (clamped to MAX_ENTRIES)
//   i_min_battery       : eligibility threshold
//   mem_bus             : memory read port (master side)
//   o_best_*            : selected entry, 16'hFFFF when none found
//   o_found             : an eligible entry was selected
//   o_busy              : scan in progress
//   o_done_read         : one-cycle completion pulse
//   o_state             : FSM state, for observation
//
// Start/done protocol: i_start_read is sampled only in IDLE; the sampling
// cycle latches all request inputs. o_busy rises the next cycle and stays
// high through the single o_done_read cycle; results change only on that
// cycle and hold until the next completion.
module cost_table_reader
    import cost_table_reader_pkg::*;
(
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  i_start_read,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [7:0]            i_num_entries,
    input  logic [WORD_WIDTH-1:0] i_min_battery,
    cost_table_reader_if.master   mem_bus,
    output logic [WORD_WIDTH-1:0] o_best_source_id,
    output logic [WORD_WIDTH-1:0] o_best_battery_stat,
    output logic [WORD_WIDTH-1:0] o_best_value,
    output logic [WORD_WIDTH-1:0] o_best_cluster_id,
    output logic                  o_found,
    output logic                  o_busy,
    output logic                  o_done_read,
    output state_t                o_state
);
    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rd_en;
    logic                  r_rd_en_d;      // read data valid this cycle
    logic [10:0]           r_reads_left;   // reads still to issue after this one
    logic [7:0]            r_entries_left;
    logic [WORD_WIDTH-1:0] r_min_battery;
    entry_t                r_run;          // running minimum
    logic                  r_run_found;
    entry_t                r_best;         // published result
    logic                  r_found;

    logic                  w_start;
    logic [7:0]            w_num_clamped;
    logic                  w_entry_valid;
    entry_t                w_entry;
    logic                  w_take;
    entry_t                w_run_next;
    logic                  w_run_found_next;

    cost_table_reader_entry_assembler u_assembler (
        .clock         (clock),
        .nreset        (nreset),
        .i_clear       (w_start),
        .i_byte_valid  (r_rd_en_d),
        .i_byte        (mem_bus.mem_rdata),
        .o_entry_valid (w_entry_valid),
        .o_entry       (w_entry)
    );

    assign w_start       = (r_state == ST_IDLE) && i_start_read;
    assign w_num_clamped = (i_num_entries > 8'(MAX_ENTRIES)) ? 8'(MAX_ENTRIES) : i_num_entries;

    // Strict '<' keeps the earlier entry on equal value.
    always_comb begin
        w_take           = 1'b0;
        w_run_next       = r_run;
        w_run_found_next = r_run_found;
        if (w_entry_valid && (w_entry.battery_stat >= r_min_battery) &&
            (!r_run_found || (w_entry.value < r_run.value))) begin
            w_take           = 1'b1;
            w_run_next       = w_entry;
            w_run_found_next = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = (w_num_clamped == 8'd0) ? ST_FINISH : ST_READ;
                end
            end
            ST_READ: begin
                if (w_entry_valid && (r_entries_left == 8'd1)) begin
                    w_state_next = ST_FINISH;
                end
            end
            ST_FINISH: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_addr         <= '0;
            r_rd_en        <= 1'b0;
            r_rd_en_d      <= 1'b0;
            r_reads_left   <= '0;
            r_entries_left <= '0;
            r_min_battery  <= '0;
            r_run          <= {4{EMPTY_WORD}};
            r_run_found    <= 1'b0;
            r_best         <= {4{EMPTY_WORD}};
            r_found        <= 1'b0;
        end else begin
            r_rd_en_d <= r_rd_en;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_min_battery  <= i_min_battery;
                        r_entries_left <= w_num_clamped;
                        r_run          <= {4{EMPTY_WORD}};
                        r_run_found    <= 1'b0;
                        if (w_num_clamped != 8'd0) begin
                            r_addr       <= i_base_addr;
                            r_rd_en      <= 1'b1;
                            r_reads_left <= {w_num_clamped, 3'b000} - 11'd1;
                        end else begin
                            r_best  <= {4{EMPTY_WORD}};
                            r_found <= 1'b0;
                        end
                    end
                end
                ST_READ: begin
                    if (r_rd_en) begin
                        if (r_reads_left == 11'd0) begin
                            r_rd_en <= 1'b0;
                        end else begin
                            // Natural 10-bit overflow gives the wrap past 1023.
                            r_addr       <= r_addr + ADDR_WIDTH'(1);
                            r_reads_left <= r_reads_left - 11'd1;
                        end
                    end
                    if (w_entry_valid) begin
                        r_entries_left <= r_entries_left - 8'd1;
                    end
                    if (w_take) begin
                        r_run       <= w_run_next;
                        r_run_found <= w_run_found_next;
                    end
                    // Publish including the final entry compared this cycle.
                    if (w_state_next == ST_FINISH) begin
                        r_best  <= w_run_next;
                        r_found <= w_run_found_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_bus.mem_addr   = r_addr;
    assign mem_bus.mem_rd_en  = r_rd_en;
    assign o_best_source_id    = r_best.source_id;
    assign o_best_battery_stat = r_best.battery_stat;
    assign o_best_value        = r_best.value;
    assign o_best_cluster_id   = r_best.cluster_id;
    assign o_found             = r_found;
    assign o_busy              = (r_state != ST_IDLE);
    assign o_done_read         = (r_state == ST_FINISH);
    assign o_state             = r_state;

endmodule
